// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the default
// register-address width and the bundle of six pipeline control strobes.
package hazard_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic flush_if_id;
        logic stall_id_ex;
        logic flush_id_ex;
        logic flush_ex_mem;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating performance counters for pipeline stalls, branch flushes and
// load-use bubbles; instantiated by hazard_ctrl only when perf is enabled.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_stall,
    input  logic             inc_flush,
    input  logic             inc_loaduse,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] loaduse_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,   flush_cnt_d;
    logic [CNT_W-1:0] loaduse_cnt_q, loaduse_cnt_d;

    // Each counter sticks at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        loaduse_cnt_d = loaduse_cnt_q;
        if (inc_stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (inc_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
        if (inc_loaduse && (loaduse_cnt_q != CNT_MAX)) begin
            loaduse_cnt_d = loaduse_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            loaduse_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            loaduse_cnt_q <= loaduse_cnt_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign loaduse_cnt = loaduse_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage core: load-use, EX branch redirect,
// imem wait states and MDU stall FSM with watchdog. Perf counters under HAZARD_PERF_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEFAULT,
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_ID,
    input  logic [REG_ADDR_W-1:0] rs2_ID,
    input  logic                  use_rs1_ID,
    input  logic                  use_rs2_ID,
    input  logic [REG_ADDR_W-1:0] rd_EX,
    input  logic                  memread_EX,
    input  logic                  branch_taken_EX,
    input  logic                  mdu_start_EX,
    input  logic                  mdu_done,
    input  logic                  imem_ready,
    output logic                  stall_PC,
    output logic                  stall_IF_ID,
    output logic                  flush_IF_ID,
    output logic                  stall_ID_EX,
    output logic                  flush_ID_EX,
    output logic                  flush_EX_MEM,
    output logic                  mdu_timeout,
    output logic                  mdu_err,
    output logic [CNT_W-1:0]      perf_stall_cnt,
    output logic [CNT_W-1:0]      perf_flush_cnt,
    output logic [CNT_W-1:0]      perf_loaduse_cnt
);

    localparam int              WD_W    = $clog2(MDU_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    hz_state_t       state_q, state_d;
    logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic            mdu_err_q, mdu_err_d;

    logic            load_use;
    logic            expire;
    logic            mdu_hold;
    hz_ctrl_t        ctrl;

    always_comb begin
        load_use = memread_EX && (rd_EX != '0) &&
                   ((use_rs1_ID && (rs1_ID == rd_EX)) ||
                    (use_rs2_ID && (rs2_ID == rd_EX)));
        expire   = (state_q == MDU_BUSY) && (wdog_cnt_q == WD_LAST) && !mdu_done;
        mdu_hold = ((state_q == RUN) && mdu_start_EX && !mdu_done) ||
                   ((state_q == MDU_BUSY) && !mdu_done && !expire);
    end

    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        wdog_cnt_d = wdog_cnt_q;
        mdu_err_d  = mdu_err_q | expire;
        case (state_q)
            RUN: begin
                wdog_cnt_d = '0;
                if (mdu_start_EX && !mdu_done) begin
                    state_d = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                if (mdu_done || (wdog_cnt_q == WD_LAST)) begin
                    state_d    = RUN;
                    wdog_cnt_d = '0;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + WD_ONE;
                end
            end
            default: begin
                state_d    = RUN;
                wdog_cnt_d = '0;
            end
        endcase
    end

    // Priority chain; reset forces every strobe low even with live inputs.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            ctrl = '0;
        end else if (mdu_hold) begin
            ctrl.stall_pc     = 1'b1;
            ctrl.stall_if_id  = 1'b1;
            ctrl.stall_id_ex  = 1'b1;
            ctrl.flush_ex_mem = 1'b1;
        end else if (branch_taken_EX) begin
            ctrl.flush_if_id  = 1'b1;
            ctrl.flush_id_ex  = 1'b1;
        end else if (load_use) begin
            ctrl.stall_pc     = 1'b1;
            ctrl.stall_if_id  = 1'b1;
            ctrl.flush_id_ex  = 1'b1;
        end else if (!imem_ready) begin
            ctrl.stall_pc     = 1'b1;
            ctrl.flush_if_id  = 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            wdog_cnt_q <= '0;
            mdu_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdog_cnt_q <= wdog_cnt_d;
            mdu_err_q  <= mdu_err_d;
        end
    end

    assign stall_PC     = ctrl.stall_pc;
    assign stall_IF_ID  = ctrl.stall_if_id;
    assign flush_IF_ID  = ctrl.flush_if_id;
    assign stall_ID_EX  = ctrl.stall_id_ex;
    assign flush_ID_EX  = ctrl.flush_id_ex;
    assign flush_EX_MEM = ctrl.flush_ex_mem;
    assign mdu_timeout  = rst && expire;
    assign mdu_err      = mdu_err_q;

`ifdef HAZARD_PERF_EN
    logic branch_flush;
    logic loaduse_bubble;

    assign branch_flush   = rst && !mdu_hold && branch_taken_EX;
    assign loaduse_bubble = rst && !mdu_hold && !branch_taken_EX && load_use;

    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .inc_stall   (ctrl.stall_pc),
        .inc_flush   (branch_flush),
        .inc_loaduse (loaduse_bubble),
        .stall_cnt   (perf_stall_cnt),
        .flush_cnt   (perf_flush_cnt),
        .loaduse_cnt (perf_loaduse_cnt)
    );
`else
    assign perf_stall_cnt   = '0;
    assign perf_flush_cnt   = '0;
    assign perf_loaduse_cnt = '0;
`endif

    // A branch redirect and an MDU start can never share a cycle in a legal pipeline.
    a_branch_mdu_excl: assert property (@(posedge clk) disable iff (!rst)
        !(branch_taken_EX && mdu_start_EX));
    a_if_id_excl: assert property (@(posedge clk) disable iff (!rst)
        !(stall_IF_ID && flush_IF_ID));
    a_id_ex_excl: assert property (@(posedge clk) disable iff (!rst)
        !(stall_ID_EX && flush_ID_EX));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MDU_TIMEOUT=8); perf counter
// expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

    localparam int RW    = 5;
    localparam int CW    = 32;
    localparam int TMO   = 8;

    // Packed view: {stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, flush_EX_MEM, mdu_timeout}
    localparam logic [6:0] V_NONE = 7'b0000000;
    localparam logic [6:0] V_LU   = 7'b1100100;
    localparam logic [6:0] V_BR   = 7'b0010100;
    localparam logic [6:0] V_MDU  = 7'b1101010;
    localparam logic [6:0] V_IMEM = 7'b1010000;
    localparam logic [6:0] V_TMO  = 7'b0000001;

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] EXP_LU_CNT = 32'd2;
    localparam logic [31:0] EXP_FL_CNT = 32'd1;
    localparam logic [31:0] EXP_ST_CNT = 32'd2;
`else
    localparam logic [31:0] EXP_LU_CNT = 32'd0;
    localparam logic [31:0] EXP_FL_CNT = 32'd0;
    localparam logic [31:0] EXP_ST_CNT = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rs1_ID, rs2_ID, rd_EX;
    logic          use_rs1_ID, use_rs2_ID, memread_EX;
    logic          branch_taken_EX, mdu_start_EX, mdu_done, imem_ready;
    logic          stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX;
    logic          flush_EX_MEM, mdu_timeout, mdu_err;
    logic [CW-1:0] perf_stall_cnt, perf_flush_cnt, perf_loaduse_cnt;
    logic [6:0]    ctrl_vec;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl #(
        .REG_ADDR_W  (RW),
        .MDU_TIMEOUT (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rs1_ID           (rs1_ID),
        .rs2_ID           (rs2_ID),
        .use_rs1_ID       (use_rs1_ID),
        .use_rs2_ID       (use_rs2_ID),
        .rd_EX            (rd_EX),
        .memread_EX       (memread_EX),
        .branch_taken_EX  (branch_taken_EX),
        .mdu_start_EX     (mdu_start_EX),
        .mdu_done         (mdu_done),
        .imem_ready       (imem_ready),
        .stall_PC         (stall_PC),
        .stall_IF_ID      (stall_IF_ID),
        .flush_IF_ID      (flush_IF_ID),
        .stall_ID_EX      (stall_ID_EX),
        .flush_ID_EX      (flush_ID_EX),
        .flush_EX_MEM     (flush_EX_MEM),
        .mdu_timeout      (mdu_timeout),
        .mdu_err          (mdu_err),
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_flush_cnt   (perf_flush_cnt),
        .perf_loaduse_cnt (perf_loaduse_cnt)
    );

    assign ctrl_vec = {stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX,
                       flush_ID_EX, flush_EX_MEM, mdu_timeout};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rs1_ID          = '0;
        rs2_ID          = '0;
        rd_EX           = '0;
        use_rs1_ID      = 1'b0;
        use_rs2_ID      = 1'b0;
        memread_EX      = 1'b0;
        branch_taken_EX = 1'b0;
        mdu_start_EX    = 1'b0;
        mdu_done        = 1'b0;
        imem_ready      = 1'b1;
    endtask

    // Move to the next falling edge with idle inputs; caller overrides then checks after #1.
    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        rst        = 1'b0;
        imem_ready = 1'b0;
        #1;
        check("reset_ctrl", 32'(ctrl_vec), 32'(V_NONE));
        check("reset_err", 32'(mdu_err), 32'd0);
        check("reset_perf_st", perf_stall_cnt, 32'd0);
        check("reset_perf_lu", perf_loaduse_cnt, 32'd0);

        next_cycle(); rst = 1'b1; #1;
        check("idle", 32'(ctrl_vec), 32'(V_NONE));

        // Load-use on rs1, then rs2, then branch over load-use + imem wait.
        next_cycle(); memread_EX = 1'b1; rd_EX = 5'd5; rs1_ID = 5'd5; use_rs1_ID = 1'b1; #1;
        check("lu_rs1", 32'(ctrl_vec), 32'(V_LU));
        next_cycle(); #1;
        check("lu_one_bubble", 32'(ctrl_vec), 32'(V_NONE));
        next_cycle(); memread_EX = 1'b1; rd_EX = 5'd7; rs2_ID = 5'd7; use_rs2_ID = 1'b1; #1;
        check("lu_rs2", 32'(ctrl_vec), 32'(V_LU));
        next_cycle(); branch_taken_EX = 1'b1; memread_EX = 1'b1; rd_EX = 5'd5;
        rs1_ID = 5'd5; use_rs1_ID = 1'b1; imem_ready = 1'b0; #1;
        check("branch_over_lu", 32'(ctrl_vec), 32'(V_BR));
        next_cycle(); #1;
        check("perf_loaduse", perf_loaduse_cnt, EXP_LU_CNT);
        check("perf_flush", perf_flush_cnt, EXP_FL_CNT);
        check("perf_stall", perf_stall_cnt, EXP_ST_CNT);

        // Non-hazards: x0 destination, unused source, non-load.
        next_cycle(); memread_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0; use_rs1_ID = 1'b1; #1;
        check("lu_rd_x0", 32'(ctrl_vec), 32'(V_NONE));
        next_cycle(); memread_EX = 1'b1; rd_EX = 5'd9; rs1_ID = 5'd9; use_rs1_ID = 1'b0; #1;
        check("lu_unused_src", 32'(ctrl_vec), 32'(V_NONE));
        next_cycle(); memread_EX = 1'b0; rd_EX = 5'd9; rs2_ID = 5'd9; use_rs2_ID = 1'b1; #1;
        check("no_load", 32'(ctrl_vec), 32'(V_NONE));

        // MDU: start, 3 busy cycles stalled, done on 4th busy cycle.
        next_cycle(); mdu_start_EX = 1'b1; #1;
        check("mdu_start", 32'(ctrl_vec), 32'(V_MDU));
        next_cycle(); #1;
        check("mdu_busy1", 32'(ctrl_vec), 32'(V_MDU));
        next_cycle(); imem_ready = 1'b0; memread_EX = 1'b1; rd_EX = 5'd3;
        rs1_ID = 5'd3; use_rs1_ID = 1'b1; #1;
        check("mdu_busy2_masks", 32'(ctrl_vec), 32'(V_MDU));
        next_cycle(); #1;
        check("mdu_busy3", 32'(ctrl_vec), 32'(V_MDU));
        next_cycle(); mdu_done = 1'b1; #1;
        check("mdu_done", 32'(ctrl_vec), 32'(V_NONE));
        next_cycle(); #1;
        check("mdu_back_run", 32'(ctrl_vec), 32'(V_NONE));

        // Start and done in the same cycle: no stall, no state change.
        next_cycle(); mdu_start_EX = 1'b1; mdu_done = 1'b1; #1;
        check("mdu_same_cycle", 32'(ctrl_vec), 32'(V_NONE));
        next_cycle(); #1;
        check("mdu_same_cycle_run", 32'(ctrl_vec), 32'(V_NONE));

        // Watchdog: no done; busy cycles 1..7 stall, cycle 8 expires.
        next_cycle(); mdu_start_EX = 1'b1; #1;
        check("wd_start", 32'(ctrl_vec), 32'(V_MDU));
        for (int i = 1; i < TMO; i++) begin
            next_cycle(); #1;
            check($sformatf("wd_busy%0d", i), 32'(ctrl_vec), 32'(V_MDU));
        end
        next_cycle(); #1;
        check("wd_expire", 32'(ctrl_vec), 32'(V_TMO));
        check("wd_err_before", 32'(mdu_err), 32'd0);
        next_cycle(); #1;
        check("wd_after", 32'(ctrl_vec), 32'(V_NONE));
        check("wd_err_set", 32'(mdu_err), 32'd1);
        next_cycle(); next_cycle(); #1;
        check("wd_err_sticky", 32'(mdu_err), 32'd1);

        // Imem wait for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            next_cycle(); imem_ready = 1'b0; #1;
            check($sformatf("imem_wait%0d", i), 32'(ctrl_vec), 32'(V_IMEM));
        end
        next_cycle(); #1;
        check("imem_ready", 32'(ctrl_vec), 32'(V_NONE));

        // Async reset in the middle of MDU_BUSY.
        next_cycle(); mdu_start_EX = 1'b1; #1;
        check("rst_mdu_start", 32'(ctrl_vec), 32'(V_MDU));
        next_cycle(); #1;
        check("rst_mdu_busy", 32'(ctrl_vec), 32'(V_MDU));
        #1 rst = 1'b0;
        #1;
        check("rst_async_ctrl", 32'(ctrl_vec), 32'(V_NONE));
        check("rst_async_err", 32'(mdu_err), 32'd0);
        next_cycle(); rst = 1'b1; #1;
        check("rst_release", 32'(ctrl_vec), 32'(V_NONE));
        next_cycle(); #1;
        check("rst_state_run", 32'(ctrl_vec), 32'(V_NONE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline hazard controller for the 5-stage pipelined RISC-V core.
- Drives stall/flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Handles load-use hazards, taken-branch redirects (resolved in EX), instruction-memory wait states and the multi-cycle MUL/DIV unit (MDU) via a small FSM with timeout watchdog.
- Sits beside the datapath; all control outputs are combinational from registered state plus current-cycle inputs.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- MDU_TIMEOUT, 64, max cycles in MDU_BUSY before forced release; must be >= 2.
- CNT_W, 32, width of perf counters (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- rs1_ID, rs2_ID  in  REG_ADDR_W  source regs of the instruction in ID.
- use_rs1_ID, use_rs2_ID  in  1  instruction in ID reads rs1/rs2.
- rd_EX  in  REG_ADDR_W  destination of the instruction in EX.
- memread_EX  in  1  EX instruction is a load.
- branch_taken_EX  in  1  taken branch/jump resolved in EX.
- mdu_start_EX  in  1  MUL/DIV in EX, first EX cycle only.
- mdu_done  in  1  MDU result valid this cycle.
- imem_ready  in  1  instruction memory returns valid fetch data.
- stall_PC  out  1  hold PC.
- stall_IF_ID, flush_IF_ID  out  1  IF/ID controls.
- stall_ID_EX, flush_ID_EX  out  1  ID/EX controls.
- flush_EX_MEM  out  1  insert bubble into EX/MEM.
- mdu_timeout  out  1  one-cycle pulse on watchdog expiry.
- mdu_err  out  1  sticky timeout flag, cleared only by reset.
- perf_stall_cnt, perf_flush_cnt, perf_loaduse_cnt  out  CNT_W  perf counters (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - FSM state is RUN; watchdog counter is 0; mdu_err is 0.
  - All stall/flush outputs and mdu_timeout are 0; perf counters are 0.
- FSM states: RUN, MDU_BUSY.
  - RUN -> MDU_BUSY: mdu_start_EX=1 and mdu_done=0.
  - MDU_BUSY -> RUN: mdu_done=1, or watchdog reaches MDU_TIMEOUT-1.
  - All other cases hold the current state.
- mdu_hold = (RUN & mdu_start_EX & !mdu_done) | (MDU_BUSY & !mdu_done & !expire).
- Watchdog:
  - Increments each MDU_BUSY cycle; cleared when entering RUN.
  - expire = (MDU_BUSY & cnt==MDU_TIMEOUT-1 & !mdu_done).
  - On expire: mdu_timeout=1 for that cycle, mdu_err set, stalls released in that cycle.
- load_use = memread_EX & rd_EX!=0 & ((use_rs1_ID & rs1_ID==rd_EX) | (use_rs2_ID & rs2_ID==rd_EX)).
- Per-cycle priority, first match wins:
  1. mdu_hold: stall_PC=1, stall_IF_ID=1, stall_ID_EX=1, flush_EX_MEM=1. Load-use and imem are ignored.
  2. branch_taken_EX: flush_IF_ID=1, flush_ID_EX=1, stall_PC=0 (PC loads target even if imem_ready=0).
  3. load_use: stall_PC=1, stall_IF_ID=1, flush_ID_EX=1. One bubble; re-evaluated next cycle.
  4. !imem_ready: stall_PC=1, flush_IF_ID=1 (bubble into ID).
  5. Otherwise all outputs are 0.
- Invariants:
  - stall_X and flush_X are never both 1 for the same register; the IF/ID register gives stall priority, so the controller must guarantee exclusivity.
  - stall_PC=1 implies branch_taken_EX is not acting.
- Illegal input combination: branch_taken_EX and mdu_start_EX together. Covered by a simulation assertion only; MDU priority applies.
- Latency:
  - Zero-cycle (combinational) response to hazard inputs.
  - FSM reacts one cycle after mdu_start_EX.
  - mdu_done in the same cycle as mdu_start_EX: no stall, no state change.
- Reset asserted mid-MDU_BUSY: immediate return to RUN and all outputs to 0.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle stall_PC=1.
  - perf_flush_cnt increments each cycle branch_taken_EX causes a flush.
  - perf_loaduse_cnt increments per load_use bubble.
  - All three saturate at all-ones.
- Undefined: ports remain present and are tied to 0; no counter flops.

Decomposition:
- hazard_pkg holds:
  - hz_state_t enum {RUN, MDU_BUSY};
  - REG_ADDR_W default constant;
  - a struct bundling the six pipeline control outputs.
- One sub-module: hazard_perf_counters, containing the saturating counters and instantiated only under HAZARD_PERF_EN.
- Hazard decode and FSM live in hazard_ctrl.

Test Plan:
- Load-use:
  - Stimulus: memread_EX=1, rd_EX=5, rs1_ID=5, use_rs1_ID=1.
  - Response: stall_PC=stall_IF_ID=flush_ID_EX=1 for 1 cycle. With rd_EX=0, all outputs are 0.
- Branch vs load-use:
  - Stimulus: branch_taken_EX=1 together with the load-use condition and imem_ready=0.
  - Response: flush_IF_ID=flush_ID_EX=1; stall_PC=0; stall_IF_ID=0.
- MDU:
  - Stimulus: mdu_start_EX pulse, mdu_done 4 cycles later.
  - Response: stall_PC, stall_IF_ID, stall_ID_EX and flush_EX_MEM are 1 for 4 cycles, 0 on the done cycle; state returns to RUN.
- Watchdog:
  - Stimulus: MDU_TIMEOUT=8, mdu_start_EX, no mdu_done.
  - Response: mdu_timeout pulses at MDU_BUSY cycle 8; mdu_err=1 and stays 1; stalls released.
- Imem wait:
  - Stimulus: imem_ready=0 for 3 cycles.
  - Response: stall_PC=flush_IF_ID=1 for 3 cycles. Then assert rst mid-MDU_BUSY: all outputs go to 0 asynchronously.
- With HAZARD_PERF_EN:
  - Stimulus: 2 load-use events and 1 branch.
  - Response: perf_loaduse_cnt=2, perf_flush_cnt=1, perf_stall_cnt=2.
